// File: rtl/omp_pkg.sv
// ============================================================================
// Module      : omp_pkg
// Description : Shared state encoding and limits for the OM-Pipe finalizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package omp_pkg;

   localparam int STATE_SIZE        = 4;
   localparam int MAX_REDUCE_CYCLES = 8;

   typedef enum logic [STATE_SIZE-1:0] {
      ST_IDLE   = 4'b0001,
      ST_ADD    = 4'b0010,
      ST_REDUCE = 4'b0100,
      ST_DONE   = 4'b1000
   } state_t;

endpackage

`default_nettype wire

// File: rtl/cond_sub.sv
// ============================================================================
// Module      : cond_sub
// Description : Combinational compare-and-subtract: ge = (a >= m), diff = a - m.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_sub #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] m,
   output logic         ge,
   output logic [W-1:0] diff
);

   assign ge   = (a >= m);
   assign diff = a - m;

endmodule

`default_nettype wire

// File: rtl/shrink_finalizer.sv
// ============================================================================
// Module      : shrink_finalizer
// Description : Reduces the redundant pair (p, q) to r = (p + q) mod n by
//               add-then-iterative-subtract. FINALIZER_RADIX4_EN enables a
//               second subtractor (s - 2n) to halve the reduce cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shrink_finalizer
   import omp_pkg::*;
#(
   parameter int N = 512
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [N:0]   p_in,
   input  logic [N:0]   q_in,
   input  logic [N-1:0] n,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] r_out,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         err
);

   state_t         state_q, state_d;
   logic [N:0]     p_q, p_d;
   logic [N:0]     q_q, q_d;
   logic [N-1:0]   nr_q, nr_d;
   logic [N+1:0]   s_q, s_d;
   logic [N-1:0]   r_q, r_d;
   logic           ov_q, ov_d;
   logic           err_q, err_d;

   logic           w_ge1;
   logic [N+1:0]   w_diff1;

   cond_sub #(.W(N+2)) u_sub1 (
      .a    (s_q),
      .m    ({2'b00, nr_q}),
      .ge   (w_ge1),
      .diff (w_diff1)
   );

`ifdef FINALIZER_RADIX4_EN
   logic           w_ge2;
   logic [N+1:0]   w_diff2;

   cond_sub #(.W(N+2)) u_sub2 (
      .a    (s_q),
      .m    ({1'b0, nr_q, 1'b0}),
      .ge   (w_ge2),
      .diff (w_diff2)
   );
`endif

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      q_d     = q_q;
      nr_d    = nr_q;
      s_d     = s_q;
      r_d     = r_q;
      ov_d    = ov_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               p_d     = p_in;
               q_d     = q_in;
               nr_d    = n;
               state_d = ST_ADD;
            end
         end
         ST_ADD: begin
            s_d = {1'b0, p_q} + {1'b0, q_q};
            // A modulus without its top bit breaks the bounded reduce count.
            if (!nr_q[N-1]) begin
               r_d     = '0;
               err_d   = 1'b1;
               ov_d    = 1'b1;
               state_d = ST_DONE;
            end else begin
               state_d = ST_REDUCE;
            end
         end
         ST_REDUCE: begin
`ifdef FINALIZER_RADIX4_EN
            if (w_ge2) begin
               s_d = w_diff2;
            end else if (w_ge1) begin
               s_d = w_diff1;
            end else begin
               r_d     = s_q[N-1:0];
               err_d   = 1'b0;
               ov_d    = 1'b1;
               state_d = ST_DONE;
            end
`else
            if (w_ge1) begin
               s_d = w_diff1;
            end else begin
               r_d     = s_q[N-1:0];
               err_d   = 1'b0;
               ov_d    = 1'b1;
               state_d = ST_DONE;
            end
`endif
         end
         ST_DONE: begin
            if (out_ready) begin
               ov_d    = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         p_q     <= '0;
         q_q     <= '0;
         nr_q    <= '0;
         s_q     <= '0;
         r_q     <= '0;
         ov_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         q_q     <= q_d;
         nr_q    <= nr_d;
         s_q     <= s_d;
         r_q     <= r_d;
         ov_q    <= ov_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = ov_q;
   assign r_out     = r_q;
   assign err       = err_q;

endmodule

`default_nettype wire
